axi_slave_frontend: RTL
=======================

AXI_SLAVE_FRONTEND -- requirements
Module: axi_slave_frontend
Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI/request address width.
REQ-002 Parameter DATA_WIDTH, default 32, AXI/request data width; full-word transfers only (no strobes).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 awaddr  input  ADDR_WIDTH  write burst start address.
REQ-006 awlen  input  8  write beats minus one.
REQ-007 awvalid  input  1  write address valid.
REQ-008 awready  output  1  write address accepted.
REQ-009 wdata  input  DATA_WIDTH  write beat data.
REQ-010 wlast  input  1  master marks final write beat.
REQ-011 wvalid  input  1  write data valid.
REQ-012 wready  output  1  write beat accepted.
REQ-013 bresp  output  2  write response, OKAY 2'b00 / SLVERR 2'b10.
REQ-014 bvalid  output  1  write response valid.
REQ-015 bready  input  1  master accepts write response.
REQ-016 araddr  input  ADDR_WIDTH  read burst start address.
REQ-017 arlen  input  8  read beats minus one.
REQ-018 arvalid  input  1  read address valid.
REQ-019 arready  output  1  read address accepted.
REQ-020 rdata  output  DATA_WIDTH  read beat data.
REQ-021 rresp  output  2  per-beat read response.
REQ-022 rlast  output  1  final read beat.
REQ-023 rvalid  output  1  read beat valid.
REQ-024 rready  input  1  master accepts read beat.
REQ-025 req_valid  output  1  single-beat request to APB master stage.
REQ-026 req_ready  input  1  APB stage accepts request.
REQ-027 req_write  output  1  1 = write, 0 = read.
REQ-028 req_addr  output  ADDR_WIDTH  beat address.
REQ-029 req_wdata  output  DATA_WIDTH  beat write data.
REQ-030 rsp_valid  input  1  one-cycle completion pulse from APB stage (no ready).
REQ-031 rsp_rdata  input  DATA_WIDTH  read data, valid with rsp_valid.
REQ-032 rsp_err  input  1  beat error (PSLVERR), valid with rsp_valid.
Function
REQ-033 FSM states IDLE, W_DATA, W_REQ, W_WAIT, W_RESP, R_REQ, R_WAIT, R_DATA; one burst in flight, no overlap of reads and writes.
REQ-034 IDLE: awready/arready asserted combinationally only for the granted channel; AW/AR both valid -> grant opposite of last granted (write first after reset).
REQ-035 AW handshake cycle N: capture awaddr/awlen, clear error flag, wready=1 in W_DATA from N+1; W handshake -> W_REQ holding wdata.
REQ-036 W_REQ/R_REQ: req_valid=1, req_* stable until req_ready; then W_WAIT/R_WAIT until rsp_valid; rsp_valid in any other state ignored.
REQ-037 Address increments by DATA_WIDTH/8 per beat, wrapping modulo 2^ADDR_WIDTH; beat counter loads awlen/arlen, decrements per completed beat.
REQ-038 W_WAIT on rsp_valid: non-final beat -> W_DATA; final beat -> W_RESP; rsp_err ORs into sticky error.
REQ-039 wlast on non-final beat: request still issued, then W_RESP with SLVERR; wlast absent on final beat: burst completes, SLVERR.
REQ-040 W_RESP: bvalid=1, bresp=SLVERR if sticky error else OKAY, held until bready, then IDLE.
REQ-041 R_WAIT on rsp_valid: register rdata=rsp_rdata, rresp=rsp_err?SLVERR:OKAY, rlast=(counter==0); R_DATA holds rvalid until rready, then R_REQ or IDLE.
REQ-042 awlen/arlen=0 is a legal single beat; 255 yields 256 beats.
Reset
REQ-043 rst_n=0 at a clock edge: state IDLE, all valid/ready outputs 0, bresp/rresp/rdata/rlast/req_* 0, grant pointer to write; in-flight burst abandoned, late rsp_valid ignored.
Structure
REQ-044 Shared package axi_apb_pkg holds the state enum, OKAY/SLVERR constants and BYTES_PER_BEAT; single flat module, no sub-module.
Verification
REQ-045 AW 0x1000 len 3, data 0xA0..0xA3, rsp OK -> req_addr 0x1000,0x1004,0x1008,0x100C; bresp 2'b00.
REQ-046 AR 0x2000 len 1, rsp_rdata 0x55/0x66, rsp_err on beat 1 -> rresp 00 then 10, rlast on second beat only.
REQ-047 AW and AR valid same cycle twice -> write granted first, read second.
REQ-048 len 2 with wlast on beat 0 -> one request issued, bresp 2'b10; len 0 at 0xFFFFFFFC then len 1 -> second beat addr 0x00000000.
REQ-049 rst_n low during W_WAIT, stray rsp_valid after -> outputs 0, state IDLE, no bvalid.

Source files
------------

// File: rtl/axi_apb_pkg.sv
// Shared definitions for the AXI-to-APB bridge front end: FSM state
// encodings, AXI response codes and the per-beat address step.
package axi_apb_pkg;

    // Burst-handling states of the front end FSM.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_W_DATA = 3'd1;
    localparam logic [2:0] ST_W_REQ  = 3'd2;
    localparam logic [2:0] ST_W_WAIT = 3'd3;
    localparam logic [2:0] ST_W_RESP = 3'd4;
    localparam logic [2:0] ST_R_REQ  = 3'd5;
    localparam logic [2:0] ST_R_WAIT = 3'd6;
    localparam logic [2:0] ST_R_DATA = 3'd7;

    // AXI response codes used on bresp/rresp.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte address advance between consecutive full-word beats.
    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

    localparam int BYTES_PER_BEAT = beat_bytes(32);

endpackage

// File: rtl/axi_slave_frontend_if.sv
// Bus bundle of the AXI slave front end: the AXI write/read channels on one
// side and the single-beat request/response link to the APB master stage.
interface axi_slave_frontend_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // AXI write address / data / response channels
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    // AXI read address / data channels
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    // Single-beat link to the APB master stage
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // Front end view
    modport slave (
        input  awaddr, awlen, awvalid, output awready,
        input  wdata, wlast, wvalid,   output wready,
        output bresp, bvalid,          input  bready,
        input  araddr, arlen, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready,
        output req_valid, input req_ready, output req_write, req_addr, req_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );

    // AXI master plus APB stage view
    modport master (
        output awaddr, awlen, awvalid, input  awready,
        output wdata, wlast, wvalid,   input  wready,
        input  bresp, bvalid,          output bready,
        output araddr, arlen, arvalid, input  arready,
        input  rdata, rresp, rlast, rvalid, output rready,
        input  req_valid, output req_ready, input req_write, req_addr, req_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/axi_slave_frontend.sv
// AXI slave front end: accepts one AXI burst at a time and splits it into
// single-beat requests for the APB master stage, collecting per-beat
// completions into the AXI write response or read data channel.
module axi_slave_frontend
    import axi_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_slave_frontend_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(beat_bytes(DATA_WIDTH));

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;       // address of the current beat
    logic [7:0]            beats_left;   // beats remaining after the current one
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wlast_q;      // master flagged the current beat as last
    logic                  err_q;        // sticky write burst error
    logic                  last_write_q; // most recent grant went to the write channel
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic                  grant_write;
    logic                  grant_read;
    logic                  final_beat;

    assign final_beat = (beats_left == 8'd0);

    // Arbitrate AW against AR while idle; simultaneous requests alternate.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        grant_write = 1'b0;
        grant_read  = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.awvalid && bus.arvalid) begin
                grant_write = !last_write_q;
                grant_read  = last_write_q;
            end else begin
                grant_write = bus.awvalid;
                grant_read  = bus.arvalid;
            end
        end
    end

    // Burst FSM together with its address, counter and response registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            beats_left   <= '0;
            wdata_q      <= '0;
            wlast_q      <= 1'b0;
            err_q        <= 1'b0;
            last_write_q <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            rlast_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_write) begin
                        addr_q       <= bus.awaddr;
                        beats_left   <= bus.awlen;
                        err_q        <= 1'b0;
                        last_write_q <= 1'b1;
                        state        <= ST_W_DATA;
                    end else if (grant_read) begin
                        addr_q       <= bus.araddr;
                        beats_left   <= bus.arlen;
                        last_write_q <= 1'b0;
                        state        <= ST_R_REQ;
                    end
                end
                ST_W_DATA: begin
                    if (bus.wvalid) begin
                        wdata_q <= bus.wdata;
                        wlast_q <= bus.wlast;
                        // wlast must coincide exactly with the final counted beat
                        if (bus.wlast != final_beat) begin
                            err_q <= 1'b1;
                        end
                        state <= ST_W_REQ;
                    end
                end
                ST_W_REQ: begin
                    if (bus.req_ready) begin
                        state <= ST_W_WAIT;
                    end
                end
                ST_W_WAIT: begin
                    if (bus.rsp_valid) begin
                        if (bus.rsp_err) begin
                            err_q <= 1'b1;
                        end
                        // An early wlast ends the burst after its beat is issued
                        if (final_beat || wlast_q) begin
                            state <= ST_W_RESP;
                        end else begin
                            beats_left <= beats_left - 8'd1;
                            addr_q     <= addr_q + ADDR_STEP;
                            state      <= ST_W_DATA;
                        end
                    end
                end
                ST_W_RESP: begin
                    if (bus.bready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_R_REQ: begin
                    if (bus.req_ready) begin
                        state <= ST_R_WAIT;
                    end
                end
                ST_R_WAIT: begin
                    if (bus.rsp_valid) begin
                        rdata_q <= bus.rsp_rdata;
                        rresp_q <= bus.rsp_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_q <= final_beat;
                        state   <= ST_R_DATA;
                    end
                end
                ST_R_DATA: begin
                    if (bus.rready) begin
                        if (rlast_q) begin
                            state <= ST_IDLE;
                        end else begin
                            beats_left <= beats_left - 8'd1;
                            addr_q     <= addr_q + ADDR_STEP;
                            state      <= ST_R_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.awready   = grant_write;
    assign bus.arready   = grant_read;
    assign bus.wready    = (state == ST_W_DATA);
    assign bus.bvalid    = (state == ST_W_RESP);
    assign bus.bresp     = err_q ? RESP_SLVERR : RESP_OKAY;
    assign bus.rvalid    = (state == ST_R_DATA);
    assign bus.rdata     = rdata_q;
    assign bus.rresp     = rresp_q;
    assign bus.rlast     = rlast_q;
    assign bus.req_valid = (state == ST_W_REQ) || (state == ST_R_REQ);
    assign bus.req_write = (state == ST_W_REQ);
    assign bus.req_addr  = addr_q;
    assign bus.req_wdata = wdata_q;

endmodule
